// File: rtl/multi_order_sigdel_if.sv
// Sample stream into the sigma-delta modulator: valid/ready handshake plus
// the signed input sample. The source drives the master side.
interface multi_order_sigdel_if #(
  parameter int W = 24
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] input_sig;

  modport master (output in_valid, output input_sig, input in_ready);
  modport slave  (input in_valid, input input_sig, output in_ready);
endinterface

// File: rtl/multi_order_sigdel.sv
// First/second-order sigma-delta modulator with saturating integrators,
// a valid/ready sample register (zero-order hold), an enable-driven run FSM
// and overload detection that clears the loop for a fixed recovery period.
module multi_order_sigdel #(
  parameter int INPUT_BITWIDTH = 24,
  parameter int GUARD_BITS     = 4,
  parameter int OVERLOAD_LIMIT = 64,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                             mod_clock,
  input  logic                             mod_reset,
  input  logic                             enable,
  input  logic                             order_sel,
  input  logic                             overload_clr,
  multi_order_sigdel_if.slave              s_in,
  output logic                             output_sig,
  output logic signed [INPUT_BITWIDTH-1:0] feedback_out,
  output logic                             overload,
  output logic                             running
);
  localparam int W  = INPUT_BITWIDTH;
  localparam int IW = W + GUARD_BITS;
  localparam int SW = IW + 2;
  localparam int CW = $clog2(OVERLOAD_LIMIT + 1);
  localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic signed [W-1:0]  FS_POS    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  FS_NEG    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX   = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN   = {3'b111, {(IW-1){1'b0}}};
  localparam logic [CW-1:0]        CNT_LIMIT = CW'(OVERLOAD_LIMIT);
  localparam logic [RW-1:0]        REC_LOAD  = RW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RECOVER} state_t;

  state_t               r_state;
  logic                 r_ord;
  logic                 r_q;
  logic                 r_overload;
  logic                 r_in_ready;
  logic signed [W-1:0]  r_x;
  logic signed [IW-1:0] r_i1;
  logic signed [IW-1:0] r_i2;
  logic [CW-1:0]        r_run_cnt;
  logic [RW-1:0]        r_rec_cnt;

  logic signed [W-1:0]  w_fb;
  logic signed [SW-1:0] w_sum1;
  logic signed [SW-1:0] w_sum2;
  logic signed [IW-1:0] w_i1n;
  logic signed [IW-1:0] w_i2n;
  logic                 w_qn;
  logic [CW-1:0]        w_cnt_n;

  // Clamp a widened sum back into the integrator range instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[IW-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[IW-1:0];
    else                  r = v[IW-1:0];
    return r;
  endfunction

  // Loop arithmetic: feedback, both integrator updates, quantiser and run length.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    w_fb   = r_q ? FS_POS : FS_NEG;
    w_sum1 = {{(SW-IW){r_i1[IW-1]}}, r_i1}
           + {{(SW-W){r_x[W-1]}}, r_x}
           - {{(SW-W){w_fb[W-1]}}, w_fb};
    w_i1n  = sat(w_sum1);
    w_sum2 = {{(SW-IW){r_i2[IW-1]}}, r_i2}
           + {{(SW-IW){w_i1n[IW-1]}}, w_i1n}
           - {{(SW-W){w_fb[W-1]}}, w_fb};
    w_i2n  = sat(w_sum2);
    w_qn   = r_ord ? ~w_i2n[IW-1] : ~w_i1n[IW-1];
    if (w_qn != r_q)                w_cnt_n = CW'(1);
    else if (r_run_cnt == CNT_LIMIT) w_cnt_n = r_run_cnt;
    else                             w_cnt_n = r_run_cnt + CW'(1);
  end

  // Run FSM, sample register, modulator state and sticky overload flag.
  // NOTE: non-blocking assignments throughout; when an overload set and a clear
  // land on the same edge, the set written later in this block takes effect.
  always_ff @(posedge mod_clock or posedge mod_reset) begin
    if (mod_reset) begin
      r_state    <= ST_IDLE;
      r_ord      <= 1'b0;
      r_q        <= 1'b0;
      r_overload <= 1'b0;
      r_in_ready <= 1'b0;
      r_x        <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_run_cnt  <= '0;
      r_rec_cnt  <= '0;
    end else begin
      if (s_in.in_valid && r_in_ready) r_x <= s_in.input_sig;
      if (overload_clr) r_overload <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (enable) begin
            r_state <= ST_RUN;
            r_ord   <= order_sel;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_i1       <= '0;
            r_i2       <= '0;
            r_q        <= 1'b0;
            r_run_cnt  <= '0;
          end else if (r_run_cnt == CNT_LIMIT) begin
            r_state    <= ST_RECOVER;
            r_in_ready <= 1'b0;
            r_overload <= 1'b1;
            r_rec_cnt  <= REC_LOAD;
            r_i1       <= '0;
            r_i2       <= '0;
            r_q        <= 1'b0;
            r_run_cnt  <= '0;
          end else begin
            r_in_ready <= 1'b1;
            r_i1       <= w_i1n;
            r_i2       <= r_ord ? w_i2n : '0;
            r_q        <= w_qn;
            r_run_cnt  <= w_cnt_n;
          end
        end
        ST_RECOVER: begin
          if (r_rec_cnt == '0) begin
            r_state    <= enable ? ST_RUN : ST_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_rec_cnt  <= r_rec_cnt - RW'(1);
            r_in_ready <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign output_sig    = r_q;
  assign feedback_out  = w_fb;
  assign overload      = r_overload;
  assign running       = (r_state == ST_RUN);
  assign s_in.in_ready = r_in_ready;

endmodule

// File: tb/tb_multi_order_sigdel.sv
// Self-checking bench for multi_order_sigdel (W=8, 4 guard bits, overload
// after 16 identical bits, 4 recovery cycles). A behavioural model predicts
// every post-edge output set into a queue; a monitor pops and compares.
module tb_multi_order_sigdel;
  localparam int W     = 8;
  localparam int LIMIT = 16;
  localparam int REC   = 4;
  localparam int IMAX  = 2047;
  localparam int IMIN  = -2048;
  localparam int FSP   = 127;
  localparam int FSN   = -128;

  typedef struct packed {
    logic       q;
    logic       run;
    logic       rdy;
    logic       ovl;
    logic [7:0] fb;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_REC} mmode_t;

  logic mod_clock = 1'b0;
  logic mod_reset;
  logic enable, order_sel, overload_clr;
  logic output_sig, overload, running;
  logic signed [W-1:0] feedback_out;

  multi_order_sigdel_if #(.W(W)) bus ();

  multi_order_sigdel #(
    .INPUT_BITWIDTH(W), .GUARD_BITS(4), .OVERLOAD_LIMIT(LIMIT), .RECOVER_CYCLES(REC)
  ) dut (
    .mod_clock(mod_clock), .mod_reset(mod_reset), .enable(enable), .order_sel(order_sel),
    .overload_clr(overload_clr), .s_in(bus), .output_sig(output_sig),
    .feedback_out(feedback_out), .overload(overload), .running(running)
  );

  always #5 mod_clock = ~mod_clock;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  // model state
  mmode_t m_mode;
  int m_i1, m_i2, m_x, m_q, m_len, m_rec_left;
  bit m_ord, m_ovl, m_ready;

  bit s_q, s_run, s_rdy, s_ovl;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_i1 = 0; m_i2 = 0; m_x = 0; m_q = 0; m_len = 0;
    m_rec_left = 0; m_ord = 0; m_ovl = 0; m_ready = 0;
  endtask

  // Predict the outputs after the coming rising edge and queue them.
  task automatic model_edge(input bit en, input bit osel, input bit vld, input int xin, input bit clr);
    exp_t e;
    int fb, a, b, v, nq;
    bit take, ovl_n;
    take  = vld && m_ready;
    ovl_n = m_ovl && !clr;
    case (m_mode)
      M_IDLE: begin
        m_ready = 1;
        if (en) begin m_mode = M_RUN; m_ord = osel; end
      end
      M_RUN: begin
        if (!en) begin
          m_mode = M_IDLE; m_i1 = 0; m_i2 = 0; m_q = 0; m_len = 0;
        end else if (m_len == LIMIT) begin
          m_mode = M_REC; m_rec_left = REC; ovl_n = 1; m_ready = 0;
          m_i1 = 0; m_i2 = 0; m_q = 0; m_len = 0;
        end else begin
          fb = (m_q != 0) ? FSP : FSN;
          a  = clamp(m_i1 + m_x - fb);
          if (m_ord) begin b = clamp(m_i2 + a - fb); v = b; end
          else begin b = 0; v = a; end
          nq = (v >= 0) ? 1 : 0;
          if (nq == m_q) m_len = (m_len < LIMIT) ? m_len + 1 : m_len;
          else m_len = 1;
          m_i1 = a; m_i2 = b; m_q = nq;
        end
      end
      M_REC: begin
        m_rec_left--;
        if (m_rec_left == 0) begin m_mode = en ? M_RUN : M_IDLE; m_ready = 1; end
      end
      default: m_mode = M_IDLE;
    endcase
    m_ovl = ovl_n;
    if (take) m_x = xin;
    e.q   = (m_q != 0);
    e.run = (m_mode == M_RUN);
    e.rdy = m_ready;
    e.ovl = m_ovl;
    e.fb  = (m_q != 0) ? 8'h7f : 8'h80;
    sb.push_back(e);
  endtask

  task automatic apply(input bit en, input bit osel, input bit vld, input int xin, input bit clr);
    enable = en; order_sel = osel; overload_clr = clr;
    bus.in_valid = vld; bus.input_sig = W'(xin);
    model_edge(en, osel, vld, xin, clr);
  endtask

  task automatic cycle(input bit en, input bit osel, input bit vld, input int xin, input bit clr);
    @(negedge mod_clock);
    apply(en, osel, vld, xin, clr);
  endtask

  task automatic sample();
    @(posedge mod_clock);
    #2;
    s_q = output_sig; s_run = running; s_rdy = bus.in_ready; s_ovl = overload;
  endtask

  task automatic count_ones(input int n, input bit osel, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      cycle(1, osel, 0, 0, 0);
      sample();
      ones += int'(s_q);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_output_sig"}, output_sig, 0);
    check({tag, "_feedback"}, feedback_out, -128);
    check({tag, "_running"}, running, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_overload"}, overload, 0);
  endtask

  // Monitor: compare the DUT outputs with the predicted set after each edge.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge mod_clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {output_sig, running, bus.in_ready, overload, feedback_out};
        check($sformatf("sb_{q,run,rdy,ovl,fb}@%0t", $time), longint'(g), longint'(e));
      end
    end
  end

  initial begin
    int ones, ones2, rec, rec2, lat, phase;
    bit rec_ok;
    logic [47:0] pat_a, pat_b;

    mod_reset = 1'b1;
    enable = 0; order_sel = 0; overload_clr = 0;
    bus.in_valid = 0; bus.input_sig = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge mod_clock);
    mod_reset = 1'b0;
    apply(0, 0, 0, 0, 0);

    // order 1, x = 0
    cycle(0, 0, 1, 0, 0);
    count_ones(16, 0, ones);
    count_ones(256, 0, ones);
    check_range("ones_o1_x0", ones, 127, 129);
    check("ovl_o1_x0", s_ovl, 0);
    cycle(0, 0, 0, 0, 0);

    // order 1, x = 64
    cycle(0, 0, 1, 64, 0);
    count_ones(16, 0, ones);
    count_ones(256, 0, ones);
    check_range("ones_o1_x64", ones, 191, 195);
    check("ovl_o1_x64", s_ovl, 0);
    cycle(0, 0, 0, 0, 0);

    // order 2, x = -32
    cycle(0, 1, 1, -32, 0);
    count_ones(16, 1, ones);
    count_ones(256, 1, ones);
    check_range("ones_o2_xm32", ones, 94, 98);
    check("ovl_o2_xm32", s_ovl, 0);
    cycle(0, 0, 0, 0, 0);

    // full-scale input: overload, recovery, samples offered during recovery refused
    cycle(0, 0, 1, 127, 0);
    ones = 0; rec = 0; rec_ok = 1; phase = 0;
    for (int k = 0; k < 40 && phase < 2; k++) begin
      cycle(1, 0, (phase == 1), -100, 0);
      sample();
      if (phase == 0) begin
        if (s_run) ones += int'(s_q);
        else begin phase = 1; rec = 1; if (s_rdy || !s_ovl) rec_ok = 0; end
      end else if (!s_run) begin
        rec++;
        if (s_rdy || !s_ovl) rec_ok = 0;
      end else phase = 2;
    end
    check("ovl_ones_before", ones, 16);
    check("recover_len", rec, 4);
    check("recover_flags", rec_ok, 1);
    check("recover_exit", phase, 2);
    ones2 = 0; rec2 = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 0, 0, 0, 0);
      sample();
      if (s_run) ones2 += int'(s_q);
      else rec2++;
    end
    check("ovl_repeat_ones", ones2, 16);
    check("ovl_repeat_rec", rec2, 4);
    check("ovl_sticky", s_ovl, 1);
    cycle(0, 0, 0, 0, 1);
    sample();
    check("ovl_cleared", s_ovl, 0);

    // order_sel changes during RUN are ignored
    cycle(0, 0, 1, 64, 0);
    for (int k = 0; k < 48; k++) begin cycle(1, 0, 0, 0, 0); sample(); pat_a[k] = s_q; end
    cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 48; k++) begin cycle(1, (k >= 10), 0, 0, 0); sample(); pat_b[k] = s_q; end
    check("order_sel_ignored", pat_b, pat_a);
    cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 40; k++) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // held samples +40 / -40 with in_valid low in between
    cycle(0, 0, 1, 40, 0);
    for (int k = 0; k < 30; k++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, -40, 0);
    for (int k = 0; k < 30; k++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // capture-to-output latency
    cycle(0, 0, 1, 127, 0);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, -128, 0);
    sample();
    check("lat_before", s_q, 1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 0, 0, 0, 0);
      sample();
      if (!s_q && lat == 0) lat = k;
    end
    check("capture_latency", lat, 2);
    cycle(0, 0, 0, 0, 0);

    // asynchronous reset in the middle of RUN with overload set and q=1
    cycle(0, 0, 1, 127, 0);
    for (int k = 0; k < 22; k++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    sample();
    check("pre_rst_run", s_run, 1);
    check("pre_rst_q", s_q, 1);
    check("pre_rst_ovl", s_ovl, 1);
    mod_reset = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    #1;
    mod_reset = 1'b0;
    model_reset();

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      int sel, xv;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: xv = 127;
        1: xv = -128;
        2: xv = 40;
        3: xv = -40;
        default: xv = int'($urandom_range(0, 255)) - 128;
      endcase
      cycle(($urandom_range(0, 99) < 95), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 15), xv, ($urandom_range(0, 99) < 4));
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0);
    @(posedge mod_clock);
    #2;
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
